// File: rtl/bravo_pkg.sv
// Shared constants and types for the player input path.
package bravo_pkg;

    // Index of each push-button within KEY / key_state.
    localparam int unsigned KEY_TURN_DONE = 0;
    localparam int unsigned KEY_DRAW      = 1;
    localparam int unsigned KEY_NEW_GAME  = 2;

    // Defaults for a 50 MHz clock: 10 ms debounce, 1 s long press.
    localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500000;
    localparam int unsigned DEF_LONG_PRESS_CYCLES = 50000000;
    localparam int unsigned DEF_CNT_W             = 26;

    // Long-press state machine for the new-game key.
    typedef enum logic [1:0] {
        StReleased,
        StHolding,
        StFired
    } lp_state_e;

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchroniser, debounce counter and registered press edge.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_state,
    output logic o_press
);

    logic [1:0]       r_sync;
    logic             r_state;
    logic             r_state_d;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic             w_level;

    // Pressed level after synchronisation (button is active-low).
    assign w_level = ~r_sync[1];

    // Synchroniser resets to released so a held key is seen as a fresh press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
        end
    end

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= 1'b0;
            r_cnt   <= '0;
        end else if (w_level == r_state) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_state <= ~r_state;
            r_cnt   <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered rising edge of the debounced level; releases produce nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_d <= 1'b0;
            r_press   <= 1'b0;
        end else begin
            r_state_d <= r_state;
            r_press   <= r_state & ~r_state_d;
        end
    end

    assign o_state = r_state;
    assign o_press = r_press;

endmodule

// File: rtl/player_input_interface.sv
// Player push-buttons to single-cycle game commands with turn gating and priority.
// Optional LONG_PRESS_NEW_GAME_EN: new_game requires holding KEY[2] for LONG_PRESS_CYCLES.
module player_input_interface
    import bravo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
    parameter int unsigned CNT_W             = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] KEY,
    input  logic       awaiting_user,
    output logic       user_turn_done,
    output logic       draw_offer,
    output logic       new_game,
    output logic [2:0] key_state
);

    localparam int unsigned MAX_CYCLES =
        (DEBOUNCE_CYCLES > LONG_PRESS_CYCLES) ? DEBOUNCE_CYCLES : LONG_PRESS_CYCLES;

    // Counters must be able to reach the larger of the two cycle limits.
    if ((64'(1) << CNT_W) <= 64'(MAX_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too small for the configured cycle counts");
    end

    logic [2:0] w_press;
    logic       w_ng_event;
    logic       w_turn_done;
    logic       w_draw;
    logic       r_draw_used;

    for (genvar i = 0; i < 3; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_key_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_key_n (KEY[i]),
            .o_state (key_state[i]),
            .o_press (w_press[i])
        );
    end

`ifdef LONG_PRESS_NEW_GAME_EN
    lp_state_e        r_lp_state;
    lp_state_e        w_lp_next;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_cnt_next;

    // Long-press state and hold counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lp_state <= StReleased;
            r_hold_cnt <= '0;
        end else begin
            r_lp_state <= w_lp_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    // Fire once after a full hold; an early release aborts silently.
    always_comb begin
        w_lp_next       = r_lp_state;
        w_hold_cnt_next = r_hold_cnt;
        w_ng_event      = 1'b0;
        unique case (r_lp_state)
            StReleased: begin
                if (w_press[KEY_NEW_GAME]) begin
                    w_lp_next       = StHolding;
                    w_hold_cnt_next = '0;
                end
            end
            StHolding: begin
                if (!key_state[KEY_NEW_GAME]) begin
                    w_lp_next = StReleased;
                end else if (r_hold_cnt == CNT_W'(LONG_PRESS_CYCLES - 1)) begin
                    w_ng_event = 1'b1;
                    w_lp_next  = StFired;
                end else begin
                    w_hold_cnt_next = r_hold_cnt + 1'b1;
                end
            end
            StFired: begin
                if (!key_state[KEY_NEW_GAME]) begin
                    w_lp_next = StReleased;
                end
            end
            default: w_lp_next = StReleased;
        endcase
    end
`else
    assign w_ng_event = w_press[KEY_NEW_GAME];
`endif

    // Gating and priority: new_game > user_turn_done > draw_offer.
    always_comb begin
        w_turn_done = w_press[KEY_TURN_DONE] & awaiting_user & ~w_ng_event;
        w_draw      = w_press[KEY_DRAW] & awaiting_user & ~r_draw_used
                      & ~w_ng_event & ~w_turn_done;
    end

    // One draw offer per turn; a finished turn or a new game re-arms it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_draw_used <= 1'b0;
        end else if (w_ng_event || w_turn_done) begin
            r_draw_used <= 1'b0;
        end else if (w_draw) begin
            r_draw_used <= 1'b1;
        end
    end

    assign new_game       = w_ng_event;
    assign user_turn_done = w_turn_done;
    assign draw_offer     = w_draw;

endmodule

// File: tb/tb_player_input_interface.sv
// Scoreboard bench for player_input_interface (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10).
// Build with LONG_PRESS_NEW_GAME_EN defined to exercise the long-press path.
module tb_player_input_interface;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 10;
    localparam int          LAT = 2 + DB + 1;

`ifdef LONG_PRESS_NEW_GAME_EN
    localparam int NG_LAT = LAT + LP;
`else
    localparam int NG_LAT = LAT;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] KEY = 3'b111;
    logic       awaiting_user = 1'b0;
    logic       user_turn_done;
    logic       draw_offer;
    logic       new_game;
    logic [2:0] key_state;

    player_input_interface #(
        .DEBOUNCE_CYCLES   (DB),
        .LONG_PRESS_CYCLES (LP),
        .CNT_W             (26)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .KEY            (KEY),
        .awaiting_user  (awaiting_user),
        .user_turn_done (user_turn_done),
        .draw_offer     (draw_offer),
        .new_game       (new_game),
        .key_state      (key_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         cyc;
        logic [2:0] p;   // {new_game, draw_offer, user_turn_done}
    } exp_t;
    exp_t sb[$];

    // Every pulse seen must match the oldest expectation in cycle and kind.
    logic [2:0] obs;
    exp_t       e;
    always @(negedge clk) begin
        obs = {new_game, draw_offer, user_turn_done};
        if (obs != 3'b000) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got %b at cycle %0d, required none", obs, cyc);
            end else begin
                e = sb.pop_front();
                if (obs !== e.p || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL pulse: got %b at cycle %0d, required %b at cycle %0d",
                             obs, cyc, e.p, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] p);
        exp_t x;
        x.cyc = c;
        x.p   = p;
        sb.push_back(x);
    endtask

    // Press key idx, hold, release and let the release debounce settle.
    task automatic press(input int idx, input int hold, input bit exp_pulse,
                         input logic [2:0] p, input int lat);
        int n;
        n = cyc;
        KEY[idx] = 1'b0;
        if (exp_pulse) push(n + lat, p);
        step(hold);
        KEY[idx] = 1'b1;
        step(DB + 6);
    endtask

    task automatic drained(input string name);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected pulses never seen, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        step(2);
        n_tests++;
        if ({new_game, draw_offer, user_turn_done, key_state} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_in: got %b, required 000000",
                     {new_game, draw_offer, user_turn_done, key_state});
        end
        rst_n = 1'b1;
        step(4);
        n_tests++;
        if ({new_game, draw_offer, user_turn_done, key_state} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_out: got %b, required 000000",
                     {new_game, draw_offer, user_turn_done, key_state});
        end
    endtask

    task automatic test_turn_done();
        int n;
        awaiting_user = 1'b1;
        step(1);
        n = cyc;
        KEY[0] = 1'b0;
        push(n + LAT, 3'b001);
        step(5);
        n_tests++;
        if (key_state !== 3'b000) begin
            n_fail++;
            $display("FAIL key_state_early: got %b, required 000", key_state);
        end
        step(1);
        n_tests++;
        if (key_state !== 3'b001) begin
            n_fail++;
            $display("FAIL key_state_pressed: got %b, required 001", key_state);
        end
        step(12);
        KEY[0] = 1'b1;
        step(DB + 6);
        n_tests++;
        if (key_state !== 3'b000) begin
            n_fail++;
            $display("FAIL key_state_released: got %b, required 000", key_state);
        end
        drained("turn_done");
    endtask

    task automatic test_draw();
        int n;
        n = cyc;
        KEY[1] = 1'b0;
        step(1);
        KEY[1] = 1'b1;
        step(1);
        KEY[1] = 1'b0;
        push(n + 2 + LAT, 3'b010);
        step(12);
        KEY[1] = 1'b1;
        step(DB + 6);
        drained("draw_bounce");
        press(1, 10, 1'b0, 3'b010, LAT);
        drained("draw_second");
        press(0, 10, 1'b1, 3'b001, LAT);
        press(1, 10, 1'b1, 3'b010, LAT);
        drained("draw_rearm");
    endtask

    task automatic test_not_awaiting();
        awaiting_user = 1'b0;
        KEY[0] = 1'b0;
        step(12);
        awaiting_user = 1'b1;
        step(6);
        KEY[0] = 1'b1;
        step(DB + 6);
        drained("not_awaiting");
    endtask

    task automatic test_simultaneous();
        int n;
        // draw_used is still set from the last draw offer.
        n = cyc;
        KEY[2] = 1'b0;
        KEY[0] = 1'b0;
`ifdef LONG_PRESS_NEW_GAME_EN
        push(n + LAT, 3'b001);
`endif
        push(n + NG_LAT, 3'b100);
        step(10);
        n_tests++;
        if (key_state !== 3'b101) begin
            n_fail++;
            $display("FAIL key_state_both: got %b, required 101", key_state);
        end
        step(14);
        KEY = 3'b111;
        step(DB + 6);
        drained("simultaneous");
        press(1, 10, 1'b1, 3'b010, LAT);
        drained("draw_cleared");
    endtask

    task automatic test_new_game_ungated();
        awaiting_user = 1'b0;
        press(2, 24, 1'b1, 3'b100, NG_LAT);
        drained("new_game_ungated");
        awaiting_user = 1'b1;
    endtask

`ifdef LONG_PRESS_NEW_GAME_EN
    task automatic test_long_press();
        // Released early enough that the debounced release lands before the hold completes.
        press(2, 9, 1'b0, 3'b100, NG_LAT);
        drained("long_short");
        press(2, 24, 1'b1, 3'b100, NG_LAT);
        drained("long_full");
    endtask
`endif

    task automatic test_reset_mid_press();
        int n;
        awaiting_user = 1'b1;
        n = cyc;
        KEY[0] = 1'b0;
        push(n + LAT, 3'b001);
        step(9);
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({new_game, draw_offer, user_turn_done, key_state} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset_held: got %b, required 000000",
                     {new_game, draw_offer, user_turn_done, key_state});
        end
        step(2);
        rst_n = 1'b1;
        n = cyc;
        push(n + LAT, 3'b001);
        step(3);
        // Second reset lands inside the debounce count.
        #3 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({new_game, draw_offer, user_turn_done, key_state} !== 6'b0) begin
            n_fail++;
            $display("FAIL async_reset_count: got %b, required 000000",
                     {new_game, draw_offer, user_turn_done, key_state});
        end
        void'(sb.pop_back());
        step(2);
        rst_n = 1'b1;
        n = cyc;
        push(n + LAT, 3'b001);
        step(14);
        KEY[0] = 1'b1;
        step(DB + 6);
        drained("reset_mid_press");
    endtask

    initial begin
        test_reset();
        test_turn_done();
        test_draw();
        test_not_awaiting();
        test_simultaneous();
        test_new_game_ungated();
`ifdef LONG_PRESS_NEW_GAME_EN
        test_long_press();
`endif
        test_reset_mid_press();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
